// File: rtl/psp_pkg.sv
// Shared types and default widths for the psp data cache.
package psp_pkg;

    localparam int PSP_ADDR_W = 32;
    localparam int PSP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

endpackage

// File: rtl/psp_dcache_store.sv
// Flop-based tag/data/valid arrays for the direct-mapped data cache.
// Combinational read by index, synchronous write, single-cycle clear of all valid bits.
module psp_dcache_store #(
    parameter int LINES  = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_clr
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/psp_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with single-word lines.
// Define PSP_DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module psp_dcache
    import psp_pkg::*;
#(
    parameter int ADDR_W      = PSP_ADDR_W,
    parameter int DATA_W      = PSP_DATA_W,
    parameter int LINES       = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] mem_data_o,
    output logic              mem_data_en
`ifdef PSP_DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    dcache_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data_i, w_mem_data_i_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;

    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_hit, w_accept;
    logic              w_we, w_clr;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [TAG_W-1:0]  w_wr_tag;
    logic [DATA_W-1:0] w_wr_data;

    psp_dcache_store #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (req_addr[IDX_W-1:0]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (w_wr_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data),
        .i_clr      (w_clr)
    );

    assign w_hit     = w_rd_valid && (w_rd_tag == req_addr[ADDR_W-1:IDX_W]);
    // Gated by rst_n so the core never sees ready while reset is held.
    assign req_ready = rst_n && (r_state == IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_data_i <= '0;
            r_mem_en     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_data_i <= w_mem_data_i_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_data_i_nxt = r_mem_data_i;
        w_mem_en_nxt     = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = '0;
        w_we             = 1'b0;
        w_clr            = 1'b0;
        w_wr_idx         = req_addr[IDX_W-1:0];
        w_wr_tag         = req_addr[ADDR_W-1:IDX_W];
        w_wr_data        = req_wdata;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_clr = 1'b1;
                end else if (w_accept) begin
                    if (req_we) begin
                        // Write-through: refresh the line only if already present.
                        w_we             = w_hit;
                        w_state_nxt      = WRITE;
                        w_mem_addr_nxt   = req_addr;
                        w_mem_data_i_nxt = req_wdata;
                        w_mem_en_nxt     = 1'b1;
                        w_resp_valid_nxt = 1'b1;
                    end else if (w_hit) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = w_rd_data;
                    end else begin
                        w_state_nxt    = FILL;
                        w_cnt_nxt      = '0;
                        w_mem_addr_nxt = req_addr;
                    end
                end
            end
            FILL: begin
                if (r_cnt == CNT_W'(MEM_LATENCY)) begin
                    w_we             = 1'b1;
                    w_wr_idx         = r_mem_addr[IDX_W-1:0];
                    w_wr_tag         = r_mem_addr[ADDR_W-1:IDX_W];
                    w_wr_data        = mem_data_o;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = mem_data_o;
                    w_state_nxt      = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WRITE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_data_i  = r_mem_data_i;
    assign mem_data_en = r_mem_en;

`ifdef PSP_DCACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    logic        w_hit_inc, w_miss_inc;

    assign w_hit_inc  = w_accept && !req_we && w_hit;
    assign w_miss_inc = w_accept && !req_we && !w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss_inc && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_psp_dcache.sv
// Directed bench for psp_dcache: vector table of single requests plus hand-written
// back-to-back, flush and mid-fill reset sequences against a latency-1 memory model.
module tb_psp_dcache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_i;
    logic [31:0] mem_rd;
    logic        mem_data_en;

    psp_dcache #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .LINES       (64),
        .MEM_LATENCY (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .flush       (flush),
        .mem_addr    (mem_addr),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_rd),
        .mem_data_en (mem_data_en)
    );

    always #5 clk = ~clk;

    // Main memory model: address sampled at the edge, data valid one cycle later.
    bit [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_data_en) mem[mem_addr[7:0]] <= mem_data_i;
        mem_rd <= mem[mem_addr[7:0]];
    end

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},   {31'b0, req_ready},   32'd0);
        check({tag, " resp_valid"},  {31'b0, resp_valid},  32'd0);
        check({tag, " resp_rdata"},  resp_rdata,           32'd0);
        check({tag, " mem_addr"},    mem_addr,             32'd0);
        check({tag, " mem_data_i"},  mem_data_i,           32'd0);
        check({tag, " mem_data_en"}, {31'b0, mem_data_en}, 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    // Issue one request; cycle 1 is the cycle after acceptance.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rd);
        int          lat;
        int          en_cnt;
        logic [31:0] a1, rd, en_a, en_d;
        lat = 0; en_cnt = 0; rd = '0; en_a = '0; en_d = '0;
        wait_ready(tag);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
        a1 = mem_addr;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (mem_data_en) begin
                en_cnt++; en_a = mem_addr; en_d = mem_data_i;
            end
            if (resp_valid) begin
                lat = c; rd = resp_rdata;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " mem_en cycles"}, en_cnt, we ? 32'd1 : 32'd0);
        if (we || exp_lat > 1) check({tag, " mem_addr"}, a1, addr);
        if (we) begin
            check({tag, " wr addr"}, en_a, addr);
            check({tag, " wr data"}, en_d, wdata);
            @(posedge clk);
            #1;
            check({tag, " mem_en drop"}, {31'b0, mem_data_en}, 32'd0);
            check({tag, " idle again"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        mem[8'h10] <= 32'hDEADBEEF;
        mem[8'h50] <= 32'hCAFEF00D;
        mem[8'h20] <= 32'h11111111;
        mem[8'h30] <= 32'h30303030;

        vecs[0]  = '{"cold load 10",   1'b0, 32'h10, 32'h0,          3, 32'hDEADBEEF};
        vecs[1]  = '{"reload 10",      1'b0, 32'h10, 32'h0,          1, 32'hDEADBEEF};
        vecs[2]  = '{"conflict 50",    1'b0, 32'h50, 32'h0,          3, 32'hCAFEF00D};
        vecs[3]  = '{"evicted 10",     1'b0, 32'h10, 32'h0,          3, 32'hDEADBEEF};
        vecs[4]  = '{"store hit 10",   1'b1, 32'h10, 32'h12345678,   1, 32'h0};
        vecs[5]  = '{"load after st",  1'b0, 32'h10, 32'h0,          1, 32'h12345678};
        vecs[6]  = '{"store miss 20",  1'b1, 32'h20, 32'hA5A5A5A5,   1, 32'h0};
        vecs[7]  = '{"load 20 noalloc", 1'b0, 32'h20, 32'h0,         3, 32'hA5A5A5A5};
        vecs[8]  = '{"refill 50",      1'b0, 32'h50, 32'h0,          3, 32'hCAFEF00D};
        vecs[9]  = '{"hit 50",         1'b0, 32'h50, 32'h0,          1, 32'hCAFEF00D};
        vecs[10] = '{"wt refill 10",   1'b0, 32'h10, 32'h0,          3, 32'h12345678};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                                 vecs[i].lat, vecs[i].rdata);

        // Back-to-back hits, one per cycle.
        wait_ready("b2b");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_addr = 32'h20;
        check("b2b first valid", {31'b0, resp_valid}, 32'd1);
        check("b2b first data", resp_rdata, 32'h12345678);
        check("b2b ready held", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b second valid", {31'b0, resp_valid}, 32'd1);
        check("b2b second data", resp_rdata, 32'hA5A5A5A5);

        // Flush wins over a simultaneous request.
        wait_ready("flush");
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        #1;
        check("flush ready low", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        check("flush no resp", {31'b0, resp_valid}, 32'd0);
        do_req("after flush 10", 1'b0, 32'h10, 32'h0, 3, 32'h12345678);

        // Reset in the middle of a fill.
        wait_ready("rst");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst fill addr", mem_addr, 32'h30);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-fill reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst hold no resp", {31'b0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post rst no resp", {31'b0, resp_valid}, 32'd0);
        end
        do_req("post rst 30", 1'b0, 32'h30, 32'h0, 3, 32'h30303030);
        do_req("post rst 10", 1'b0, 32'h10, 32'h0, 3, 32'h12345678);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
